// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: default sizing for the slide-switch debouncer and a config legality check.
package sw_debounce_pkg;

    localparam int SW_N_DEFAULT      = 10;
    localparam int SW_STABLE_DEFAULT = 1000000;
    localparam int SW_CNT_W_DEFAULT  = 20;
    localparam int SW_STABLE_SIM     = 8;

    function automatic bit sw_stable_ok(input int stable, input int cnt_w);
        return stable >= 2 && longint'(stable) <= (longint'(1) << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: one switch bit - 2-flop synchroniser, stability counter, clean level and edge flops.
// Edge flops exist only when SW_EDGE_DETECT_EN is defined.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = SW_STABLE_DEFAULT,
    parameter int CNT_W         = SW_CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             clean_q, clean_d;
    logic             accept;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter tops out at LAST and clears on acceptance, so it never wraps.
    always_comb begin
        accept  = (sync2_q != clean_q) && (cnt_q == LAST);
        clean_d = accept ? sync2_q : clean_q;
        cnt_d   = (sync2_q == clean_q || accept) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clean_o = clean_q;

`ifdef SW_EDGE_DETECT_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= accept & sync2_q;
            fall_q <= accept & ~sync2_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: debounces N_SW slide switches into clean levels plus edge pulses.
// Edge outputs are live only with SW_EDGE_DETECT_EN defined; otherwise they are constant 0.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int N_SW          = SW_N_DEFAULT,
    parameter int STABLE_CYCLES = SW_STABLE_DEFAULT,
    parameter int CNT_W         = SW_CNT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_clean,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            sw_changed
);

    if (!sw_stable_ok(STABLE_CYCLES, CNT_W)) begin : g_bad_cfg
        $error("sw_debounce: STABLE_CYCLES must be in 2..2**CNT_W-1");
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (sw_raw[i]),
            .clean_o(sw_clean[i]),
            .rise_o (sw_rise[i]),
            .fall_o (sw_fall[i])
        );
    end

`ifdef SW_EDGE_DETECT_EN
    // Pure OR of the registered edge flops, so it pulses in the same cycle as them.
    assign sw_changed = |(sw_rise | sw_fall);
`else
    assign sw_changed = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: table-driven scoreboard bench for sw_debounce at STABLE_CYCLES=8.
// Expected edge outputs follow SW_EDGE_DETECT_EN: pulses when defined, constant 0 otherwise.
`timescale 1ns/1ps
module tb_sw_debounce;
    import sw_debounce_pkg::*;

    localparam int N = SW_N_DEFAULT;
    localparam int S = SW_STABLE_SIM;
`ifdef SW_EDGE_DETECT_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    typedef struct {
        string        tag;
        logic         rst;
        logic [N-1:0] raw;
        int           n;
        logic [N-1:0] clean;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } vec_t;

    typedef struct {
        string        tag;
        logic [N-1:0] clean;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic         chg;
    } exp_t;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic [N-1:0] sw_raw = '0;
    logic [N-1:0] sw_clean, sw_rise, sw_fall;
    logic         sw_changed;

    vec_t         tbl[$];
    exp_t         sb[$];
    exp_t         m;
    int           n_vec = 0;
    int           n_err = 0;
    logic [N-1:0] cur_clean = '0;

    always #5 clk = ~clk;

    sw_debounce #(
        .N_SW         (N),
        .STABLE_CYCLES(S),
        .CNT_W        (SW_CNT_W_DEFAULT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .sw_clean  (sw_clean),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_changed(sw_changed)
    );

    // One record = n edges; outputs hold until the last edge, which shows (clean, rise, fall).
    function automatic void add(input string tag, input logic rst, input logic [N-1:0] raw, input int n,
                                input logic [N-1:0] clean, input logic [N-1:0] rise, input logic [N-1:0] fall);
        vec_t v;
        v.tag = tag; v.rst = rst; v.raw = raw; v.n = n;
        v.clean = clean; v.rise = rise; v.fall = fall;
        tbl.push_back(v);
    endfunction

    task automatic drive(input string tag, input logic rst, input logic [N-1:0] raw,
                         input logic [N-1:0] clean, input logic [N-1:0] rise, input logic [N-1:0] fall);
        exp_t e;
        @(negedge clk);
        reset  = rst;
        sw_raw = raw;
        e.tag   = tag;
        e.clean = rst ? '0 : clean;
        e.rise  = (rst || !EDGE_EN) ? '0 : rise;
        e.fall  = (rst || !EDGE_EN) ? '0 : fall;
        e.chg   = |(e.rise | e.fall);
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            m = sb.pop_front();
            n_vec++;
            if (sw_clean !== m.clean || sw_rise !== m.rise || sw_fall !== m.fall || sw_changed !== m.chg) begin
                n_err++;
                $display("FAIL %s @%0t: got clean=%h rise=%h fall=%h chg=%b, want clean=%h rise=%h fall=%h chg=%b",
                         m.tag, $time, sw_clean, sw_rise, sw_fall, sw_changed, m.clean, m.rise, m.fall, m.chg);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] r;
        int           hi, lo;
        add("reset",        1, 10'h3FF,  2, 10'h000, 10'h000, 10'h000);
        add("por_rise",     0, 10'h3FF, 10, 10'h3FF, 10'h3FF, 10'h000);
        add("por_hold",     0, 10'h3FF,  3, 10'h3FF, 10'h000, 10'h000);
        add("all_fall",     0, 10'h000, 10, 10'h000, 10'h000, 10'h3FF);
        add("step0",        0, 10'h001, 10, 10'h001, 10'h001, 10'h000);
        add("step0_hold",   0, 10'h001,  4, 10'h001, 10'h000, 10'h000);
        add("bounce3_h1",   0, 10'h009,  3, 10'h001, 10'h000, 10'h000);
        add("bounce3_l1",   0, 10'h001,  3, 10'h001, 10'h000, 10'h000);
        add("bounce3_h2",   0, 10'h009,  3, 10'h001, 10'h000, 10'h000);
        add("bounce3_l2",   0, 10'h001,  3, 10'h001, 10'h000, 10'h000);
        add("bounce3_rise", 0, 10'h009, 10, 10'h009, 10'h008, 10'h000);
        add("bounce3_hold", 0, 10'h009,  3, 10'h009, 10'h000, 10'h000);
        add("glitch5",      0, 10'h029,  7, 10'h009, 10'h000, 10'h000);
        add("glitch5_tail", 0, 10'h009, 12, 10'h009, 10'h000, 10'h000);
        add("prep2",        0, 10'h00D, 10, 10'h00D, 10'h004, 10'h000);
        add("simul_lead",   0, 10'h30D,  2, 10'h00D, 10'h000, 10'h000);
        add("simul_rise98", 0, 10'h309,  8, 10'h30D, 10'h300, 10'h000);
        add("simul_fall2",  0, 10'h309,  2, 10'h309, 10'h000, 10'h004);
        add("simul_hold",   0, 10'h309,  3, 10'h309, 10'h000, 10'h000);
        add("midcnt_count", 0, 10'h30B,  7, 10'h309, 10'h000, 10'h000);
        add("midcnt_reset", 1, 10'h30B,  1, 10'h000, 10'h000, 10'h000);
        add("midcnt_rise",  0, 10'h30B, 10, 10'h30B, 10'h30B, 10'h000);
        add("midcnt_hold",  0, 10'h30B,  3, 10'h30B, 10'h000, 10'h000);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                if (k == tbl[i].n - 1)
                    drive(tbl[i].tag, tbl[i].rst, tbl[i].raw, tbl[i].clean, tbl[i].rise, tbl[i].fall);
                else
                    drive(tbl[i].tag, tbl[i].rst, tbl[i].raw, cur_clean, '0, '0);
            end
            cur_clean = tbl[i].rst ? '0 : tbl[i].clean;
        end

        // Random bounce on bit 7: high phases shorter than S must never be accepted.
        for (int b = 0; b < 6; b++) begin
            hi = $urandom_range(1, S - 1);
            lo = $urandom_range(1, 4);
            for (int k = 0; k < hi; k++) drive("rand_bounce7", 0, 10'h38B, 10'h30B, '0, '0);
            for (int k = 0; k < lo; k++) drive("rand_bounce7", 0, 10'h30B, 10'h30B, '0, '0);
        end
        for (int k = 0; k < S + 4; k++) drive("rand_bounce7_tail", 0, 10'h30B, 10'h30B, '0, '0);

        // A pulse exactly S cycles long on bit 4 is accepted, then debounced back down.
        for (int k = 1; k <= 18; k++) begin
            r = (k <= S) ? 10'h31B : 10'h30B;
            drive("exact_pulse4", 0, r, (k >= 10 && k < 18) ? 10'h31B : 10'h30B,
                  (k == 10) ? 10'h010 : 10'h000, (k == 18) ? 10'h010 : 10'h000);
        end
        for (int k = 0; k < 2; k++) drive("exact_pulse4_hold", 0, 10'h30B, 10'h30B, '0, '0);

        @(negedge clk);
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Conditions raw slide-switch inputs (SW0..SW9) before they are packed into the CPU input ports.
- Sits between the board switch pins and the in_port packers: per-bit 2-flop synchroniser, then a per-bit stability counter.
- Gives the CPU glitch-free levels plus single-cycle edge pulses.
- Runs on the main board clock.

Parameters:
- N_SW, 10, number of switch bits handled.
- STABLE_CYCLES, 1000000, consecutive cycles a synchronised level must differ from the clean level before it is accepted (20 ms at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 20, stability counter width.

Ports:
- clk  input  1  board clock.
- reset  input  1  synchronous, active-high reset.
- sw_raw  input  N_SW  asynchronous switch pins; bit i = SWi.
- sw_clean  output  N_SW  debounced level, registered.
- sw_rise  output  N_SW  one-cycle pulse in the cycle sw_clean[i] goes 0->1.
- sw_fall  output  N_SW  one-cycle pulse in the cycle sw_clean[i] goes 1->0.
- sw_changed  output  1  OR of sw_rise|sw_fall, registered with them.

Behaviour:
- Reset (sampled on clk rising edge while reset=1) clears:
  - sync1, sync2 and all counters
  - sw_clean, sw_rise, sw_fall, sw_changed
- Reset has priority over every other event.
- Reset mid-count discards the partial count; reset held for 1 cycle is sufficient.
- Synchroniser: sync1 <= sw_raw; sync2 <= sync1 (2 flops per bit, no logic between them).
- Per bit i, each edge when not in reset:
  - sync2[i] == sw_clean[i]: cnt[i] <= 0.
  - sync2[i] != sw_clean[i] and cnt[i] != STABLE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - sync2[i] != sw_clean[i] and cnt[i] == STABLE_CYCLES-1: sw_clean[i] <= sync2[i]; cnt[i] <= 0.
- Latency: if sw_raw[i] is first sampled at the new level at edge e0 and stays there, sw_clean[i] updates at edge e0+STABLE_CYCLES+1.
- Bounce: any return of sync2[i] to sw_clean[i] before the count completes resets cnt[i] to 0. Pulses shorter than STABLE_CYCLES never reach sw_clean.
- Edge pulses:
  - sw_rise/sw_fall/sw_changed are registered and asserted in the same cycle sw_clean changes.
  - High for exactly 1 cycle, otherwise 0.
  - Back-to-back accepted toggles are at least STABLE_CYCLES apart, so pulses never merge.
- Bits are fully independent. Simultaneous changes on several bits give simultaneous pulses; sw_changed is a single pulse.
- Counter never wraps: it tops out at STABLE_CYCLES-1 and then clears. Elaboration error if STABLE_CYCLES > 2^CNT_W-1 or STABLE_CYCLES < 2.
- Switch held at 1 through reset: sw_clean rises STABLE_CYCLES+1 cycles after the first post-reset sample, with a sw_rise pulse. Software must tolerate a power-on rise.

Optional Feature:
- Macro SW_EDGE_DETECT_EN.
- Defined: sw_rise, sw_fall, sw_changed implemented as described.
- Undefined: those three outputs tied to constant 0, and no edge registers are synthesised. sw_clean is unaffected and its timing is identical.

Decomposition:
- Package sw_debounce_pkg holds:
  - SW_N_DEFAULT = 10
  - SW_STABLE_DEFAULT = 1000000
  - SW_CNT_W_DEFAULT = 20
  - sim constant SW_STABLE_SIM = 8
- One sub-module, sw_debounce_bit: the synchroniser, counter, clean flop and edge flops for one bit.
- sw_debounce instantiates sw_debounce_bit N_SW times via generate and ORs the edges for sw_changed.

Test Plan (STABLE_CYCLES=8):
- Reset/idle: reset for 2 cycles with sw_raw=10'h3FF, then release. All outputs are 0 during reset. sw_clean=10'h3FF exactly 9 edges after the first post-reset sample, with sw_rise=10'h3FF and sw_changed=1 for 1 cycle.
- Clean step: sw_raw[0] 0->1 steady. sw_clean[0]=1 at e0+9; sw_rise[0] high for that single cycle only; sw_fall=0 throughout.
- Bounce: sw_raw[3] toggles 1,0,1,0 with 3-cycle phases, then holds 1. sw_clean[3] stays 0 during bouncing and rises 9 edges after the final transition is first sampled; exactly one sw_rise[3] pulse.
- Glitch rejection: sw_raw[5] pulses high for 7 cycles, then returns to 0. sw_clean[5] never changes and no edge pulses occur.
- Simultaneous and independent bits: sw_raw[9:8] 00->11 at the same edge while sw_raw[2] falls 1->0 two cycles later.
  - sw_rise[9:8]=2'b11 in one cycle.
  - sw_fall[2] pulses 2 cycles later.
  - sw_changed pulses in both cycles.
- Reset mid-count: sw_raw[1] goes high; assert reset when cnt=5. Counter clears, sw_clean[1] stays 0, and after release the rise occurs 9 edges after the first post-reset sample. Repeat with SW_EDGE_DETECT_EN undefined: edge outputs remain 0 throughout.
